// File: rtl/snake_pkg.sv
// Shared direction codes, FSM state encoding and direction helpers for the
// snake body engine.
package snake_pkg;

  localparam logic [1:0] DIR_YP = 2'd0;
  localparam logic [1:0] DIR_YM = 2'd1;
  localparam logic [1:0] DIR_XM = 2'd2;
  localparam logic [1:0] DIR_XP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    logic [1:0] o;
    case (d)
      DIR_YP:  o = DIR_YM;
      DIR_YM:  o = DIR_YP;
      DIR_XM:  o = DIR_XP;
      DIR_XP:  o = DIR_XM;
      default: o = DIR_YM;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/snake_next_pos.sv
// Combinational one-cell move of a board position; the board edge either
// wraps around or is reported as a wall hit.
module snake_next_pos
  import snake_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int WRAP   = 1
) (
  input  logic [XW-1:0] pos_x,
  input  logic [YW-1:0] pos_y,
  input  logic [1:0]    dir,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic          wall_hit
);

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_MIN = {XW{1'b0}};
  localparam logic [YW-1:0] Y_MIN = {YW{1'b0}};

  // On a wall hit the position is held so a frozen head stays put.
  always_comb begin
    next_x   = pos_x;
    next_y   = pos_y;
    wall_hit = 1'b0;
    case (dir)
      DIR_YP: begin
        if (pos_y != Y_MAX) next_y = pos_y + YW'(1);
        else if (WRAP != 0) next_y = Y_MIN;
        else                wall_hit = 1'b1;
      end
      DIR_YM: begin
        if (pos_y != Y_MIN) next_y = pos_y - YW'(1);
        else if (WRAP != 0) next_y = Y_MAX;
        else                wall_hit = 1'b1;
      end
      DIR_XM: begin
        if (pos_x != X_MIN) next_x = pos_x - XW'(1);
        else if (WRAP != 0) next_x = X_MAX;
        else                wall_hit = 1'b1;
      end
      DIR_XP: begin
        if (pos_x != X_MAX) next_x = pos_x + XW'(1);
        else if (WRAP != 0) next_x = X_MIN;
        else                wall_hit = 1'b1;
      end
      default: begin
        next_x   = pos_x;
        next_y   = pos_y;
        wall_hit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake engine: owns head and body segments, applies direction requests,
// handles wrap/wall, food growth and self-collision, and serves render reads.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int XW       = 4,
  parameter int YW       = 4,
  parameter int MAX_LEN  = 16,
  parameter int LW       = 5,
  parameter int INIT_X   = 2,
  parameter int INIT_Y   = 3,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic [1:0]    control,
  input  logic [XW-1:0] food_x,
  input  logic [YW-1:0] food_y,
  input  logic          food_valid,
  input  logic [LW-1:0] seg_idx,
  output logic [XW-1:0] seg_x,
  output logic [YW-1:0] seg_y,
  input  logic [XW-1:0] q_x,
  input  logic [YW-1:0] q_y,
  output logic          q_hit,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic [1:0]    dir,
  output logic          ate,
  output logic          dead
);

  state_t        state_r;
  state_t        state_next_s;
  logic [XW-1:0] seg_x_r [MAX_LEN];
  logic [YW-1:0] seg_y_r [MAX_LEN];
  logic [LW-1:0] length_r;
  logic [1:0]    dir_r;
  logic [1:0]    pending_r;
  logic          ate_r;

  logic [XW-1:0] next_x_s;
  logic [YW-1:0] next_y_s;
  logic          wall_hit_s;
  logic          eat_s;
  logic          collide_s;
  logic [LW-1:0] coll_lim_s;
  logic          run_s;
  logic          dead_s;
  logic          init_s;
  logic          move_s;
  logic [XW-1:0] seg_x_s;
  logic [YW-1:0] seg_y_s;
  logic          q_hit_s;

  snake_next_pos #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .XW     (XW),
    .YW     (YW),
    .WRAP   (WRAP)
  ) u_next_pos (
    .pos_x    (seg_x_r[0]),
    .pos_y    (seg_y_r[0]),
    .dir      (pending_r),
    .next_x   (next_x_s),
    .next_y   (next_y_s),
    .wall_hit (wall_hit_s)
  );

  // Eat detection and body collision; the tail cell only counts when growing.
  always_comb begin
    eat_s      = food_valid && (next_x_s == food_x) && (next_y_s == food_y);
    coll_lim_s = eat_s ? length_r : (length_r - LW'(1));
    collide_s  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      collide_s = collide_s | ((LW'(i) < coll_lim_s) &&
                               (seg_x_r[i] == next_x_s) && (seg_y_r[i] == next_y_s));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (step && (wall_hit_s || collide_s)) state_next_s = DEAD;
        else                                   state_next_s = RUN;
      end
      DEAD: begin
        if (start) state_next_s = RUN;
        else       state_next_s = DEAD;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    run_s  = 1'b0;
    dead_s = 1'b0;
    case (state_r)
      IDLE: begin
        run_s  = 1'b0;
        dead_s = 1'b0;
      end
      RUN:     run_s  = 1'b1;
      DEAD:    dead_s = 1'b1;
      default: begin
        run_s  = 1'b0;
        dead_s = 1'b0;
      end
    endcase
  end

  // start out of IDLE/DEAD re-initialises the body; start beats a concurrent step.
  assign init_s = start && !run_s;
  assign move_s = run_s && step && !wall_hit_s && !collide_s;

  // Body, length, direction and eat pulse.
  always_ff @(posedge clk) begin
    if (rst || init_s) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_x_r[i] <= XW'(INIT_X);
          seg_y_r[i] <= YW'(INIT_Y - i);
        end else begin
          seg_x_r[i] <= {XW{1'b0}};
          seg_y_r[i] <= {YW{1'b0}};
        end
      end
      length_r  <= LW'(INIT_LEN);
      dir_r     <= DIR_YP;
      pending_r <= DIR_YP;
      ate_r     <= 1'b0;
    end else begin
      if (control == opposite(dir_r)) pending_r <= pending_r;
      else                            pending_r <= control;
      ate_r <= move_s && eat_s;
      if (move_s) begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          seg_x_r[i] <= seg_x_r[i-1];
          seg_y_r[i] <= seg_y_r[i-1];
        end
        seg_x_r[0] <= next_x_s;
        seg_y_r[0] <= next_y_s;
        dir_r      <= pending_r;
        if (eat_s && (length_r < LW'(MAX_LEN))) length_r <= length_r + LW'(1);
        else                                    length_r <= length_r;
      end else begin
        dir_r    <= dir_r;
        length_r <= length_r;
      end
    end
  end

  // Renderer reads: indexed segment and occupancy query over live segments only.
  always_comb begin
    seg_x_s = {XW{1'b0}};
    seg_y_s = {YW{1'b0}};
    q_hit_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_x_s = seg_x_s | (seg_x_r[i] & {XW{(LW'(i) == seg_idx) && (LW'(i) < length_r)}});
      seg_y_s = seg_y_s | (seg_y_r[i] & {YW{(LW'(i) == seg_idx) && (LW'(i) < length_r)}});
      q_hit_s = q_hit_s | ((LW'(i) < length_r) && (seg_x_r[i] == q_x) && (seg_y_r[i] == q_y));
    end
  end

  assign seg_x  = seg_x_s;
  assign seg_y  = seg_y_s;
  assign q_hit  = q_hit_s;
  assign head_x = seg_x_r[0];
  assign head_y = seg_y_r[0];
  assign length = length_r;
  assign dir    = dir_r;
  assign ate    = ate_r;
  assign dead   = dead_s;

endmodule
